cycle_count_tx: RTL and testbench
=================================

Name: cycle_count_tx

Overview:
- Transmit side for the 64-bit cycle counter.
- Captures a snapshot of the running counter value on each `snap` pulse and queues it in a small snapshot FIFO.
- Sends each snapshot downstream as a sequence of OUT_W-bit beats on a valid/ready stream, low word first, with a last flag.
- Sits between the cycle counter and the host readout/DMA path; lets software collect multiple timestamps without tearing.

Parameters:
- CNT_W, 64, width of the sampled counter value; must be an integer multiple of OUT_W.
- OUT_W, 32, width of one output beat; BEATS = CNT_W/OUT_W (2 by default).
- DEPTH, 4, snapshot FIFO depth in entries; power of two, at least 2.
- DROP_W, 16, width of the dropped-snapshot counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- counter_in  input  CNT_W  live cycle-counter value.
- snap  input  1  snapshot request; sampled each rising edge, one request per high cycle.
- out_data  output  OUT_W  current beat.
- out_valid  output  1  beat available.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high on the final beat of a snapshot.
- level  output  $clog2(DEPTH)+1  number of snapshots queued, including the one in transmission.
- drop_cnt  output  DROP_W  snapshots lost because the FIFO was full; saturating.
- clear_drop  input  1  synchronous clear of drop_cnt.

Behaviour:
- Reset (rst low, async): FIFO empty, write/read pointers 0, beat index 0.
- Reset values: out_valid=0, out_last=0, out_data=0, level=0, drop_cnt=0.
- Reset mid-transmission discards all queued and partially sent snapshots; no resumption.
- Capture:
  - When snap=1 at an edge, counter_in sampled at that edge is written to the FIFO tail, if space exists.
  - Write occurs in the same cycle; the entry is visible at the output no earlier than the next cycle.
- Full:
  - If level==DEPTH and snap=1, the snapshot is dropped and drop_cnt increments.
  - drop_cnt saturates at all-ones.
  - Exception: if the head's final beat handshakes (out_valid & out_ready & out_last) in the same cycle, the slot frees and the snap is accepted; no drop.
- Empty: level==0 gives out_valid=0. A snap into an empty FIFO yields out_valid=1 on the following cycle.
- Serialisation:
  - Beat index b runs 0..BEATS-1; out_data = head[b*OUT_W +: OUT_W].
  - out_last = (b==BEATS-1) && out_valid.
  - On out_valid & out_ready: b increments. On the last beat, b returns to 0 and the head is popped (read pointer +1, wrapping mod DEPTH).
- Stream rules:
  - out_valid, once high, stays high until handshake.
  - out_data and out_last are held stable while out_valid & !out_ready.
  - out_valid does not depend combinationally on out_ready.
- Back-to-back: the last beat of snapshot N may be followed by beat 0 of snapshot N+1 in the next cycle, giving one beat per cycle at full throughput.
- level:
  - +1 on an accepted snap, -1 on final-beat pop, unchanged when both occur.
  - Registered; reflects events of the previous edge.
- clear_drop=1 zeroes drop_cnt. A simultaneous drop event is lost, since clear has priority.
- Pointer wrap: write/read pointers are $clog2(DEPTH) bits, wrapping naturally; full/empty are decided by level.

Test Plan:
- Single snapshot: counter_in=64'h0000_0001_0000_00A5, snap one cycle, out_ready=1 → next cycle out_data=32'h0000_00A5/last=0, then 32'h0000_0001/last=1, then out_valid=0, level returns to 0.
- Backpressure: snapshot 64'hDEAD_BEEF_1234_5678, out_ready=0 for 5 cycles → out_data held at 32'h1234_5678, out_valid=1; after out_ready=1, beats 32'h1234_5678 then 32'hDEAD_BEEF.
- Overflow: out_ready=0, 6 snap pulses with values 1..6, DEPTH=4 → level=4, drop_cnt=2; draining yields 1,2,3,4 in order (8 beats), then clear_drop sets drop_cnt=0.
- Full pop+push: FIFO full, snap=1 in the same cycle as the final-beat handshake → drop_cnt unchanged, level stays 4, new value transmitted last.
- Saturation: force 65540 drops with DROP_W=16 → drop_cnt=16'hFFFF.
- Async reset mid-stream: rst low after beat 0 of a snapshot with 2 entries queued → out_valid=0 and level=0 immediately; after release, a new snap sends beat 0 (low word) first.

Source files
------------

// File: rtl/cycle_count_tx.sv
// Snapshot FIFO for the 64-bit cycle counter. Each snap request is queued here,
// then sent downstream as OUT_W-bit valid/ready beats, low word first.
module cycle_count_tx #(
    parameter int CNT_W  = 64,
    parameter int OUT_W  = 32,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         counter_in,
    input  logic                     snap,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clear_drop
);

    localparam int BEATS  = CNT_W / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    logic [CNT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [BEAT_W-1:0] r_beat;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_valid;
    logic              w_last_beat;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_head;
    logic [OUT_W-1:0]  w_beat_data;

    // Valid comes from the registered level only, so it never depends on out_ready.
    assign w_valid     = (r_level != '0);
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_pop       = w_valid & out_ready & w_last_beat;
    // A final-beat pop frees the head slot in time for a snap in the same cycle.
    assign w_push      = snap & (~w_full | w_pop);
    assign w_drop      = snap & ~w_push;

    assign w_head      = r_mem[r_rptr];
    assign w_beat_data = w_head[int'(r_beat) * OUT_W +: OUT_W];

    assign out_valid = w_valid;
    assign out_last  = w_valid & w_last_beat;
    assign out_data  = w_valid ? w_beat_data : '0;
    assign level     = r_level;
    assign drop_cnt  = r_drop_cnt;

    // NOTE: storage has no reset; an entry is only read after it has been written,
    // and leaving it out keeps the array mappable onto plain RAM/flop banks.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= counter_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_beat  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_valid && out_ready) begin
                r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
            end
        end
    end

    // Clear wins over a simultaneous drop; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (clear_drop) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_cycle_count_tx.sv
// Directed bench for cycle_count_tx: a queue-based snapshot model is compared on
// every falling edge, plus literal expectations from hand-worked scenarios.
module tb_cycle_count_tx;

    localparam int CNT_W  = 64;
    localparam int OUT_W  = 32;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;
    localparam int BEATS  = CNT_W / OUT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [CNT_W-1:0]  counter_in = '0;
    logic              snap = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [$clog2(DEPTH):0] level;
    logic [DROP_W-1:0] drop_cnt;
    logic              clear_drop = 1'b0;

    int errors = 0;
    int checks = 0;

    cycle_count_tx #(
        .CNT_W(CNT_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .counter_in(counter_in), .snap(snap),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .level(level), .drop_cnt(drop_cnt),
        .clear_drop(clear_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queued snapshots, index of the next beat of the head, drop count.
    logic [CNT_W-1:0] m_q[$];
    int               m_beat = 0;
    int               m_drops = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_q.delete();
                m_beat  = 0;
                m_drops = 0;
            end else begin
                int  size_before;
                bit  popped;
                size_before = m_q.size();
                popped = 1'b0;
                if (size_before > 0 && out_ready) begin
                    if (m_beat == BEATS - 1) begin
                        void'(m_q.pop_front());
                        m_beat = 0;
                        popped = 1'b1;
                    end else begin
                        m_beat++;
                    end
                end
                if (clear_drop) begin
                    m_drops = 0;
                end
                if (snap) begin
                    if (size_before < DEPTH || popped) begin
                        m_q.push_back(counter_in);
                    end else if (!clear_drop && m_drops < 65535) begin
                        m_drops++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [63:0] exp_data;
                bit          exp_valid;
                exp_valid = (m_q.size() != 0);
                exp_data  = exp_valid ? ((m_q[0] >> (m_beat * OUT_W)) & 64'hFFFF_FFFF) : 64'h0;
                check("model_valid", {63'h0, out_valid}, {63'h0, exp_valid});
                check("model_data",  {32'h0, out_data}, exp_data);
                check("model_last",  {63'h0, out_last}, {63'h0, exp_valid && (m_beat == BEATS - 1)});
                check("model_level", {61'h0, level}, 64'(m_q.size()));
                check("model_drop",  {48'h0, drop_cnt}, 64'(m_drops));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_last",  {63'h0, out_last}, 64'h0);
        check("rst_data",  {32'h0, out_data}, 64'h0);
        check("rst_level", {61'h0, level}, 64'h0);
        check("rst_drop",  {48'h0, drop_cnt}, 64'h0);
        rst = 1'b1;
        step();

        // Single snapshot
        counter_in = 64'h0000_0001_0000_00A5; snap = 1'b1; out_ready = 1'b1;
        step();
        snap = 1'b0;
        check("single_b0_valid", {63'h0, out_valid}, 64'h1);
        check("single_b0_data",  {32'h0, out_data}, 64'h0000_00A5);
        check("single_b0_last",  {63'h0, out_last}, 64'h0);
        check("single_level",    {61'h0, level}, 64'h1);
        step();
        check("single_b1_data",  {32'h0, out_data}, 64'h0000_0001);
        check("single_b1_last",  {63'h0, out_last}, 64'h1);
        step();
        check("single_done_valid", {63'h0, out_valid}, 64'h0);
        check("single_done_level", {61'h0, level}, 64'h0);

        // Backpressure
        out_ready = 1'b0; counter_in = 64'hDEAD_BEEF_1234_5678; snap = 1'b1;
        step();
        snap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data",  {32'h0, out_data}, 64'h1234_5678);
            check("bp_hold_valid", {63'h0, out_valid}, 64'h1);
            step();
        end
        out_ready = 1'b1;
        check("bp_b0_data", {32'h0, out_data}, 64'h1234_5678);
        step();
        check("bp_b1_data", {32'h0, out_data}, 64'hDEAD_BEEF);
        check("bp_b1_last", {63'h0, out_last}, 64'h1);
        step();
        check("bp_done_valid", {63'h0, out_valid}, 64'h0);

        // Overflow: six snaps into a four-deep FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            counter_in = 64'(i); snap = 1'b1;
            step();
        end
        snap = 1'b0;
        check("ovf_level", {61'h0, level}, 64'h4);
        check("ovf_drop",  {48'h0, drop_cnt}, 64'h2);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("ovf_drain_data", {32'h0, out_data}, (k % 2 == 0) ? 64'(k / 2 + 1) : 64'h0);
            step();
        end
        check("ovf_empty_valid", {63'h0, out_valid}, 64'h0);
        clear_drop = 1'b1;
        step();
        clear_drop = 1'b0;
        check("ovf_clear_drop", {48'h0, drop_cnt}, 64'h0);

        // Full FIFO: push in the same cycle as the head's final-beat handshake
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            counter_in = 64'hA000_0000_0000_0011 + 64'(i); snap = 1'b1;
            step();
        end
        snap = 1'b0;
        out_ready = 1'b1;
        step();
        check("pp_head_last", {63'h0, out_last}, 64'h1);
        counter_in = 64'hBBBB_CCCC_DDDD_EEEE; snap = 1'b1;
        step();
        snap = 1'b0;
        check("pp_drop",  {48'h0, drop_cnt}, 64'h0);
        check("pp_level", {61'h0, level}, 64'h4);
        for (int i = 0; i < 6; i++) step();
        check("pp_new_lo", {32'h0, out_data}, 64'hDDDD_EEEE);
        step();
        check("pp_new_hi",   {32'h0, out_data}, 64'hBBBB_CCCC);
        check("pp_new_last", {63'h0, out_last}, 64'h1);
        step();
        check("pp_empty", {63'h0, out_valid}, 64'h0);

        // Drop counter saturation: 4 accepted then 65540 dropped
        out_ready = 1'b0; snap = 1'b1; counter_in = 64'h55;
        for (int i = 0; i < 4 + 65540; i++) step();
        snap = 1'b0;
        check("sat_drop",  {48'h0, drop_cnt}, 64'hFFFF);
        check("sat_level", {61'h0, level}, 64'h4);

        // Async reset mid-stream
        rst = 1'b0;
        #3;
        rst = 1'b1;
        step();
        counter_in = 64'h0000_0002_0000_0001; snap = 1'b1;
        step();
        counter_in = 64'h0000_0004_0000_0003;
        step();
        snap = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ar_pre_level", {61'h0, level}, 64'h2);
        check("ar_pre_data",  {32'h0, out_data}, 64'h0000_0002);
        #1;
        rst = 1'b0;
        #1;
        check("ar_valid", {63'h0, out_valid}, 64'h0);
        check("ar_level", {61'h0, level}, 64'h0);
        #4;
        rst = 1'b1;
        step();
        counter_in = 64'h7777_7777_0000_0042; snap = 1'b1; out_ready = 1'b1;
        step();
        snap = 1'b0;
        check("ar_new_b0", {32'h0, out_data}, 64'h0000_0042);
        check("ar_new_b0_last", {63'h0, out_last}, 64'h0);
        step();
        check("ar_new_b1", {32'h0, out_data}, 64'h7777_7777);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
